// File: rtl/ad9361_ctrl_seq.sv
// AD9361 RESETB/ENABLE pin sequencer: holds the device in reset, waits for it to settle,
// then drives ENABLE in level or pulse mode and flags the device as usable.
module ad9361_ctrl_seq #(
    parameter int RST_LOW_CYCLES  = 1000,
    parameter int RST_WAIT_CYCLES = 20000,
    parameter int EN_PULSE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_rstb,
    input  logic       req_en,
    input  logic       pulse_mode,
    output logic       pin_resetb,
    output logic       pin_enable,
    output logic       ready,
    output logic [1:0] state_o
);

    localparam logic [1:0] ST_RESET_LOW = 2'd0;
    localparam logic [1:0] ST_SETTLE    = 2'd1;
    localparam logic [1:0] ST_READY     = 2'd2;

    localparam int PW = (EN_PULSE_CYCLES > 1) ? $clog2(EN_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RST_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RST_WAIT_CYCLES - 1);
    localparam logic [PW-1:0]    P_LAST    = PW'(EN_PULSE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             en_prev_q, en_prev_d;
    logic             pen_q, pen_d;
    logic             gap_q, gap_d;
    logic             pend_q, pend_d;
    logic             chg;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_prev_d = 1'b0;
        pen_d     = 1'b0;
        gap_d     = 1'b0;
        pend_d    = 1'b0;
        pcnt_d    = '0;
        chg       = req_en ^ en_prev_q;

        case (state_q)
            ST_RESET_LOW: begin
                // Counter saturates at the last low cycle until the request releases.
                if (cnt_q != LOW_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (req_rstb) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: cnt_d = '0;
            default: begin
                state_d = ST_RESET_LOW;
                cnt_d   = '0;
            end
        endcase

        if (!req_rstb && state_q != ST_RESET_LOW) begin
            state_d = ST_RESET_LOW;
            cnt_d   = '0;
        end

        // ENABLE only runs while staying in READY; the entry cycle sees en_prev as 0,
        // and leaving READY clears the pin in the same edge as the state change.
        if (state_q == ST_READY && state_d == ST_READY) begin
            en_prev_d = req_en;
            if (!pulse_mode) begin
                pen_d = req_en;
            end else if (pen_q) begin
                pend_d = pend_q ^ chg;
                if (pcnt_q == P_LAST) begin
                    gap_d = 1'b1;
                end else begin
                    pen_d  = 1'b1;
                    pcnt_d = pcnt_q + 1'b1;
                end
            end else if (gap_q) begin
                if (pcnt_q == P_LAST) begin
                    pen_d = pend_q ^ chg;
                end else begin
                    gap_d  = 1'b1;
                    pcnt_d = pcnt_q + 1'b1;
                    pend_d = pend_q ^ chg;
                end
            end else begin
                pen_d = chg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET_LOW;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            en_prev_q <= 1'b0;
            pen_q     <= 1'b0;
            gap_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            en_prev_q <= en_prev_d;
            pen_q     <= pen_d;
            gap_q     <= gap_d;
            pend_q    <= pend_d;
        end
    end

    assign pin_resetb = (state_q != ST_RESET_LOW);
    assign ready      = (state_q == ST_READY);
    assign pin_enable = pen_q;
    assign state_o    = state_q;

endmodule
